// File: rtl/intt_pkg.sv
// Shared definitions for the INTT control unit: FSM encoding, geometry,
// twiddle ROM layout and twiddle fan-out codes.
package intt_pkg;

  localparam int WORDS   = 512;
  localparam int ADDR_W  = 9;
  localparam int TF_W    = 11;
  localparam int STAGE_W = 4;

  localparam logic [3:0] TF_SEL_S0  = 4'd11;
  localparam logic [3:0] TF_SEL_S1  = 4'd10;
  localparam logic [3:0] TF_SEL_OFF = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } intt_state_t;

  typedef struct packed {
    logic              we;
    logic              half;
    logic              scale;
    logic [ADDR_W-1:0] addr;
  } wr_ctl_t;

  // Each stage s owns max(WORDS >> s, 1) consecutive twiddle words in the ROM.
  function automatic logic [TF_W-1:0] tf_base(input logic [STAGE_W-1:0] s);
    logic [TF_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < (1 << STAGE_W); k++) begin
      if (k < int'(s)) begin
        acc = acc + (((WORDS >> k) > 1) ? TF_W'(WORDS >> k) : TF_W'(1));
      end
    end
    return acc;
  endfunction

  function automatic logic [3:0] tf_sel_code(input logic [STAGE_W-1:0] s);
    logic [3:0] code;
    code = TF_SEL_OFF;
    if (s == STAGE_W'(0)) code = TF_SEL_S0;
    else if (s == STAGE_W'(1)) code = TF_SEL_S1;
    return code;
  endfunction

endpackage

// File: rtl/intt_dly_line.sv
// Fixed-depth shift register used to align control with the datapath pipeline.
module intt_dly_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/intt_cu.sv
// Control unit for an in-place Gentleman-Sande INTT: sequences LOG_N stages of
// 512 word reads, with writes ping-ponging between the a_r and a_l halves.
module intt_cu
  import intt_pkg::*;
#(
  parameter int LOG_N                = 12,
  parameter int COMMON_BRAM_DELAY    = 2,
  parameter int COMMON_NTT_PIP_DELAY = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              intt_start,
  output logic              coe_mux_sel,
  output logic [3:0]        tf_mux_sel,
  output logic              swap_mux0_sel,
  output logic              o_scale_en,
  output logic              o_we_a_l,
  output logic              o_we_a_r,
  output logic [ADDR_W-1:0] o_addr_a_l,
  output logic [ADDR_W-1:0] o_addr_a_r,
  output logic [ADDR_W-1:0] o_addr_b_l,
  output logic [ADDR_W-1:0] o_addr_b_r,
  output logic [TF_W-1:0]   o_addr_tf,
  output logic              o_busy,
  output logic              intt_done
);

  localparam int DRAIN_W = $clog2(COMMON_NTT_PIP_DELAY + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(COMMON_NTT_PIP_DELAY - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG_N - 1);
  localparam logic [ADDR_W-1:0]  LAST_WORD  = ADDR_W'(WORDS - 1);

  intt_state_t        state;
  logic [STAGE_W-1:0] stage;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_active;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               busy;
  logic               done;

  wire last_stage = (stage == LAST_STAGE);

  // DRAIN waits out the pipeline so the next stage never reads a word before
  // the previous stage has written it back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      stage     <= '0;
      rd_addr   <= '0;
      rd_active <= 1'b0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (intt_start) begin
            state     <= ST_RUN;
            stage     <= '0;
            rd_addr   <= '0;
            rd_active <= 1'b1;
            busy      <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (rd_addr == LAST_WORD) begin
            rd_addr   <= '0;
            rd_active <= 1'b0;
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            if (last_stage) begin
              state <= ST_DONE;
              stage <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ST_RUN;
              stage     <= stage + STAGE_W'(1);
              rd_active <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  wr_ctl_t wr_in;
  wr_ctl_t wr_out;

  always_comb begin
    wr_in       = '0;
    wr_in.we    = rd_active;
    wr_in.half  = rd_active & stage[0];
    wr_in.scale = rd_active & last_stage;
    wr_in.addr  = rd_addr;
  end

  intt_dly_line #(
    .WIDTH($bits(wr_ctl_t)),
    .DEPTH(COMMON_NTT_PIP_DELAY)
  ) u_wr_dly (
    .clk (clk),
    .rst (rst),
    .din (wr_in),
    .dout(wr_out)
  );

  logic [3:0] tf_sel_in;
  assign tf_sel_in = rd_active ? tf_sel_code(stage) : TF_SEL_OFF;

  intt_dly_line #(
    .WIDTH(4),
    .DEPTH(COMMON_BRAM_DELAY)
  ) u_tf_sel_dly (
    .clk (clk),
    .rst (rst),
    .din (tf_sel_in),
    .dout(tf_mux_sel)
  );

  // Swap select must settle two cycles ahead of the write it steers.
  logic swap_in;
  assign swap_in = rd_active & (stage < STAGE_W'(3));

  intt_dly_line #(
    .WIDTH(1),
    .DEPTH(COMMON_NTT_PIP_DELAY - 2)
  ) u_swap_dly (
    .clk (clk),
    .rst (rst),
    .din (swap_in),
    .dout(swap_mux0_sel)
  );

  assign o_addr_b_l  = rd_addr;
  assign o_addr_b_r  = rd_addr;
  assign coe_mux_sel = rd_active & stage[0];
  assign o_addr_tf   = rd_active ? (tf_base(stage) + TF_W'(rd_addr >> stage)) : '0;

  assign o_we_a_r   = wr_out.we & ~wr_out.half;
  assign o_we_a_l   = wr_out.we & wr_out.half;
  assign o_addr_a_r = o_we_a_r ? wr_out.addr : '0;
  assign o_addr_a_l = o_we_a_l ? wr_out.addr : '0;
  assign o_scale_en = wr_out.scale;

  assign o_busy    = busy;
  assign intt_done = done;

endmodule

// File: tb/tb_intt_cu.sv
// Scoreboard bench for intt_cu: a cycle-level model derived from the stage
// schedule plus a write-order queue filled at each accepted start.
module tb_intt_cu;

  localparam int LOG_N   = 12;
  localparam int BRAM    = 2;
  localparam int PIP     = 9;
  localparam int WORDS   = 512;
  localparam int STAGE_P = WORDS + PIP;
  localparam int RUN_CYC = LOG_N * STAGE_P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        intt_start = 1'b0;
  logic        coe_mux_sel;
  logic [3:0]  tf_mux_sel;
  logic        swap_mux0_sel;
  logic        o_scale_en;
  logic        o_we_a_l, o_we_a_r;
  logic [8:0]  o_addr_a_l, o_addr_a_r, o_addr_b_l, o_addr_b_r;
  logic [10:0] o_addr_tf;
  logic        o_busy;
  logic        intt_done;

  intt_cu #(
    .LOG_N(LOG_N),
    .COMMON_BRAM_DELAY(BRAM),
    .COMMON_NTT_PIP_DELAY(PIP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .intt_start   (intt_start),
    .coe_mux_sel  (coe_mux_sel),
    .tf_mux_sel   (tf_mux_sel),
    .swap_mux0_sel(swap_mux0_sel),
    .o_scale_en   (o_scale_en),
    .o_we_a_l     (o_we_a_l),
    .o_we_a_r     (o_we_a_r),
    .o_addr_a_l   (o_addr_a_l),
    .o_addr_a_r   (o_addr_a_r),
    .o_addr_b_l   (o_addr_b_l),
    .o_addr_b_r   (o_addr_b_r),
    .o_addr_tf    (o_addr_tf),
    .o_busy       (o_busy),
    .intt_done    (intt_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       half;
    logic [8:0] addr;
    logic       scale;
  } wr_t;

  typedef struct packed {
    logic [8:0]  addr_b;
    logic        coe;
    logic [10:0] tf;
    logic [3:0]  tfsel;
    logic        swap;
    logic        we_l;
    logic        we_r;
    logic [8:0]  addr_a_l;
    logic [8:0]  addr_a_r;
    logic        scale;
    logic        busy;
    logic        done;
  } exp_t;

  wr_t wq[$];
  int  cyc = 0;
  int  origin = 0;
  bit  origin_valid = 1'b0;
  int  errors = 0;
  int  checks = 0;
  int  done_count = 0;
  int  exp_dones = 0;
  int  flush_req = 0;
  int  flush_ack = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int tfBase(input int s);
    int b;
    b = 0;
    for (int k = 0; k < s; k++) b += ((WORDS >> k) > 1) ? (WORDS >> k) : 1;
    return b;
  endfunction

  // Expected outputs in cycle t for a run whose start pulse was in cycle origin.
  function automatic exp_t modelAt(input int t);
    exp_t e;
    int k, s, p, j;
    e = '0;
    if (!origin_valid || t <= origin || t > origin + RUN_CYC + 1) return e;
    k = t - origin - 1;
    if (k == RUN_CYC) begin
      e.done = 1'b1;
      return e;
    end
    e.busy = 1'b1;
    s = k / STAGE_P;
    p = k % STAGE_P;
    if (p < WORDS) begin
      e.addr_b = 9'(p);
      e.coe    = 1'(s % 2);
      e.tf     = 11'(tfBase(s) + (p >> s));
    end
    if (p >= BRAM && p < WORDS + BRAM)
      e.tfsel = (s == 0) ? 4'd11 : (s == 1) ? 4'd10 : 4'd0;
    if (p >= PIP - 2 && p < WORDS + PIP - 2 && s < 3) e.swap = 1'b1;
    if (p >= PIP && p < WORDS + PIP) begin
      j = p - PIP;
      if (s % 2 == 1) begin
        e.we_l     = 1'b1;
        e.addr_a_l = 9'(j);
      end else begin
        e.we_r     = 1'b1;
        e.addr_a_r = 9'(j);
      end
      e.scale = (s == LOG_N - 1);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: per-cycle model comparison plus write-order scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    wr_t  w;
    logic [8:0] wr_addr;
    e = modelAt(cyc);
    checkOutput("read", {o_addr_b_l, o_addr_b_r, coe_mux_sel}, {e.addr_b, e.addr_b, e.coe});
    checkOutput("twiddle", {o_addr_tf, tf_mux_sel}, {e.tf, e.tfsel});
    checkOutput("write", {o_we_a_l, o_we_a_r, o_addr_a_l, o_addr_a_r, o_scale_en},
                {e.we_l, e.we_r, e.addr_a_l, e.addr_a_r, e.scale});
    checkOutput("ctrl", {swap_mux0_sel, o_busy, intt_done}, {e.swap, e.busy, e.done});
    if (o_we_a_l || o_we_a_r) begin
      wr_addr = o_we_a_l ? o_addr_a_l : o_addr_a_r;
      if (wq.size() == 0) begin
        checkOutput("wr_unexpected", {o_we_a_l, o_we_a_r}, 2'b00);
      end else begin
        w = wq.pop_front();
        checkOutput("wr_order", {o_we_a_l, o_we_a_r, wr_addr, o_scale_en},
                    {w.half, ~w.half, w.addr, w.scale});
      end
    end
    if (intt_done) done_count++;
    if (flush_req != flush_ack) begin
      checkOutput("wq_empty", 64'(wq.size()), 64'd0);
      checkOutput("done_count", 64'(done_count), 64'(exp_dones));
      flush_ack = flush_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) tick();
  endtask

  function automatic bit modelBusy();
    return origin_valid && (cyc <= origin + RUN_CYC);
  endfunction

  // One-cycle start pulse in the current cycle; queues the whole run if accepted.
  task automatic applyStimulus();
    intt_start = 1'b1;
    if (!modelBusy()) begin
      origin       = cyc;
      origin_valid = 1'b1;
      exp_dones++;
      for (int s = 0; s < LOG_N; s++)
        for (int j = 0; j < WORDS; j++)
          wq.push_back('{half: 1'(s % 2), addr: 9'(j), scale: (s == LOG_N - 1)});
    end
    tick();
    intt_start = 1'b0;
  endtask

  task automatic applyReset(input int len);
    rst = 1'b1;
    if (modelBusy()) exp_dones--;
    origin_valid = 1'b0;
    wq.delete();
    repeat (len) tick();
    rst = 1'b0;
  endtask

  task automatic requestFlush();
    flush_req++;
    tick();
    tick();
  endtask

  initial begin
    int base;
    $display("[TB] intt_cu scoreboard bench");
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Run with starts ignored while busy, including the one at +3000.
    waitUntil(cyc + int'($urandom_range(2, 9)));
    base = cyc;
    applyStimulus();
    waitUntil(base + int'($urandom_range(10, 2999)));
    applyStimulus();
    waitUntil(base + 3000);
    applyStimulus();
    waitUntil(base + int'($urandom_range(3001, 6251)));
    applyStimulus();
    waitUntil(base + RUN_CYC + 4);
    requestFlush();

    // Reset at +2000 aborts the run; restart at +2010 completes from stage 0.
    waitUntil(cyc + int'($urandom_range(1, 15)));
    base = cyc;
    applyStimulus();
    waitUntil(base + 2000);
    applyReset(3);
    waitUntil(base + 2010);
    applyStimulus();
    waitUntil(base + 2010 + RUN_CYC + 4);
    requestFlush();

    // Randomly timed reset and restart.
    waitUntil(cyc + int'($urandom_range(1, 15)));
    base = cyc;
    applyStimulus();
    waitUntil(base + int'($urandom_range(10, 6200)));
    applyReset(int'($urandom_range(1, 4)));
    waitUntil(cyc + int'($urandom_range(1, 20)));
    base = cyc;
    applyStimulus();
    waitUntil(base + RUN_CYC + 4);
    requestFlush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
